truthtab_capture: RTL and testbench

Sequential truth-table capture engine for small combinational blocks such as a 4-input function-minimization circuit. On `start` it steps the function's input vector through every code, 0 to 2^WIDTH-1. After a settle window it samples the function's 1-bit output at each code and assembles the full truth table. It then compares the table against an expected minterm mask and reports pass/fail. It is the response/reader end of exhaustive stimulus sweeps and replaces free-running testbench loops with a synthesizable checker usable on hardware.

---
 rtl/truthtab_capture_if.sv | 35 +++
 rtl/truthtab_capture.sv | 148 ++++++++++++++
 tb/tb_truthtab_capture.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/truthtab_capture_if.sv
// rtl/truthtab_capture_if.sv - sweep control, result and function-under-test signals (TRUTHTAB_ERRLOG_EN adds the error log)
interface truthtab_capture_if #(
    parameter int WIDTH = 4
);
    logic                    start;
    logic [(1<<WIDTH)-1:0]   expected;
    logic [WIDTH-1:0]        dut_in;
    logic                    dut_out;
    logic                    busy;
    logic                    done;
    logic [(1<<WIDTH)-1:0]   table_out;
    logic                    pass;
`ifdef TRUTHTAB_ERRLOG_EN
    logic                    err_valid;
    logic [WIDTH-1:0]        err_idx;

    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, table_out, pass, err_valid, err_idx
    );
    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, table_out, pass, err_valid, err_idx
    );
`else
    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, table_out, pass
    );
    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, table_out, pass
    );
`endif
endinterface

// File: rtl/truthtab_capture.sv
// rtl/truthtab_capture.sv - exhaustive truth-table capture and compare engine (optional first-mismatch log: TRUTHTAB_ERRLOG_EN)
module truthtab_capture #(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    truthtab_capture_if.slave bus
);
    localparam int N  = 1 << WIDTH;
    // A settle window shorter than one cycle would sample the previous code.
    localparam int SC = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int CW = (SC > 1) ? $clog2(SC) : 1;
    localparam logic [WIDTH-1:0] IDX_LAST = WIDTH'(N - 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(SC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] idx_q;
    logic [CW-1:0]    cnt_q;
    logic [N-1:0]     exp_q;
    logic [N-1:0]     tab_q;
    logic             pass_q;
    logic             busy_c;
    logic             done_c;
`ifdef TRUTHTAB_ERRLOG_EN
    logic             errv_q;
    logic [WIDTH-1:0] erri_q;
`endif

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status decode: busy covers every non-idle state.
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy_c = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy_c = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: code index, settle counter, captured table and verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            exp_q  <= '0;
            tab_q  <= '0;
            pass_q <= 1'b0;
`ifdef TRUTHTAB_ERRLOG_EN
            errv_q <= 1'b0;
            erri_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        exp_q  <= bus.expected;
                        tab_q  <= '0;
                        pass_q <= 1'b0;
                        idx_q  <= '0;
                        cnt_q  <= '0;
`ifdef TRUTHTAB_ERRLOG_EN
                        errv_q <= 1'b0;
                        erri_q <= '0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_SAMPLE: begin
                    tab_q[idx_q] <= bus.dut_out;
`ifdef TRUTHTAB_ERRLOG_EN
                    if ((bus.dut_out != exp_q[idx_q]) && !errv_q) begin
                        errv_q <= 1'b1;
                        erri_q <= idx_q;
                    end
`endif
                    // idx stays on the last code after the sweep.
                    if (idx_q != IDX_LAST) begin
                        idx_q <= idx_q + WIDTH'(1);
                    end
                end
                S_DONE: begin
                    pass_q <= (tab_q == exp_q);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.dut_in    = idx_q;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.table_out = tab_q;
    assign bus.pass      = pass_q;
`ifdef TRUTHTAB_ERRLOG_EN
    assign bus.err_valid = errv_q;
    assign bus.err_idx   = erri_q;
`endif

endmodule

// File: tb/tb_truthtab_capture.sv
// tb/tb_truthtab_capture.sv - scoreboard bench for truthtab_capture (SETTLE_CYC=2 and SETTLE_CYC=1 instances)
module tb_truthtab_capture;

    typedef struct {
        int          done_at;
        int          busy_n;
        logic [15:0] tab;
        logic        pass;
        logic        errv;
        logic [3:0]  erri;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    logic [1:0] fs0, fs1;
    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    bit   cur_ok[2];
    int   bc0, bc1, s0, s1;
    bit   pb0, pb1, pend0, pend1;
    int   last_c0;

    truthtab_capture_if #(.WIDTH(4)) if0 ();
    truthtab_capture_if #(.WIDTH(4)) if1 ();

    truthtab_capture #(.WIDTH(4), .SETTLE_CYC(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    truthtab_capture #(.WIDTH(4), .SETTLE_CYC(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // Functions under test; a..d are dut_in bits 3..0.
    function automatic logic fmodel(input logic [1:0] s, input logic [3:0] x);
        case (s)
            2'd0:    return ^x;
            2'd1:    return (!x[3] && x[2]) || (x[1] && x[0]);
            default: return 1'b0;
        endcase
    endfunction

    assign if0.dut_out = fmodel(fs0, if0.dut_in);
    assign if1.dut_out = fmodel(fs1, if1.dut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int idx_exp(input int k, input int sc);
        int v;
        v = (k - 1) / (sc + 1);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic push(input int inst, input logic [1:0] fs, input logic [15:0] m,
                        input int c0, input int sc);
        exp_t e;
        e.tab  = '0;
        e.errv = 1'b0;
        e.erri = '0;
        for (int i = 0; i < 16; i++) begin
            e.tab[i] = fmodel(fs, 4'(i));
            if (!e.errv && (e.tab[i] != m[i])) begin
                e.errv = 1'b1;
                e.erri = 4'(i);
            end
        end
        e.pass    = (e.tab == m);
        e.busy_n  = 16 * (sc + 1) + 1;
        e.done_at = c0 + e.busy_n;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic on_done(input int inst, input int bc);
        exp_t e;
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            check("unexpected_done", 32'd1, 32'd0);
            cur_ok[inst] = 1'b0;
        end else begin
            if (inst == 0) e = q0.pop_front();
            else           e = q1.pop_front();
            cur[inst]    = e;
            cur_ok[inst] = 1'b1;
            check("done_cycle", cyc, e.done_at);
            check("busy_len", bc, e.busy_n);
        end
    endtask

    task automatic post(input int inst, input logic [15:0] tab, input logic pass,
                        input logic done, input logic errv, input logic [3:0] erri);
        check("done_pulse", {31'd0, done}, 32'd0);
        if (cur_ok[inst]) begin
            check("table_out", {16'd0, tab}, {16'd0, cur[inst].tab});
            check("pass", {31'd0, pass}, {31'd0, cur[inst].pass});
`ifdef TRUTHTAB_ERRLOG_EN
            check("err_valid", {31'd0, errv}, {31'd0, cur[inst].errv});
            if (cur[inst].errv) check("err_idx", {28'd0, erri}, {28'd0, cur[inst].erri});
`else
            check("err_unused", {27'd0, errv, erri}, 32'd0);
`endif
        end
    endtask

    // Monitor, SETTLE_CYC=2 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            bc0 = 0; pend0 = 1'b0; pb0 = 1'b0;
        end else begin
            if (if0.busy && !pb0) s0 = cyc - 1;
            pb0 = if0.busy;
            if (if0.busy) begin
                bc0++;
                check("dut_in0", {28'd0, if0.dut_in}, idx_exp(cyc - s0, 2));
            end
            if (if0.done) begin
                on_done(0, bc0);
                bc0 = 0;
                pend0 = 1'b1;
            end else if (pend0) begin
`ifdef TRUTHTAB_ERRLOG_EN
                post(0, if0.table_out, if0.pass, if0.done, if0.err_valid, if0.err_idx);
`else
                post(0, if0.table_out, if0.pass, if0.done, 1'b0, 4'd0);
`endif
                pend0 = 1'b0;
            end
        end
    end

    // Monitor, SETTLE_CYC=1 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            bc1 = 0; pend1 = 1'b0; pb1 = 1'b0;
        end else begin
            if (if1.busy && !pb1) s1 = cyc - 1;
            pb1 = if1.busy;
            if (if1.busy) begin
                bc1++;
                check("dut_in1", {28'd0, if1.dut_in}, idx_exp(cyc - s1, 1));
            end
            if (if1.done) begin
                on_done(1, bc1);
                bc1 = 0;
                pend1 = 1'b1;
            end else if (pend1) begin
`ifdef TRUTHTAB_ERRLOG_EN
                post(1, if1.table_out, if1.pass, if1.done, if1.err_valid, if1.err_idx);
`else
                post(1, if1.table_out, if1.pass, if1.done, 1'b0, 4'd0);
`endif
                pend1 = 1'b0;
            end
        end
    end

    task automatic go(input int inst, input logic [1:0] fs, input logic [15:0] m, input bit hold);
        @(negedge clk);
        if (inst == 0) begin
            fs0 = fs; if0.expected = m; if0.start = 1'b1;
        end else begin
            fs1 = fs; if1.expected = m; if1.start = 1'b1;
        end
        last_c0 = cyc;
        push(inst, fs, m, cyc, (inst == 0) ? 2 : 1);
        if (!hold) begin
            @(negedge clk);
            if (inst == 0) if0.start = 1'b0;
            else           if1.start = 1'b0;
        end
    endtask

    task automatic drain(input int inst, input int budget);
        int n;
        n = 0;
        while (((inst == 0) ? (q0.size() != 0 || pend0) : (q1.size() != 0 || pend1)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dut_in"}, {28'd0, if0.dut_in}, 32'd0);
        check({tag, "_busy"}, {31'd0, if0.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, if0.done}, 32'd0);
        check({tag, "_table"}, {16'd0, if0.table_out}, 32'd0);
        check({tag, "_pass"}, {31'd0, if0.pass}, 32'd0);
`ifdef TRUTHTAB_ERRLOG_EN
        check({tag, "_err_valid"}, {31'd0, if0.err_valid}, 32'd0);
        check({tag, "_err_idx"}, {28'd0, if0.err_idx}, 32'd0);
`endif
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        fs0 = 2'd0; fs1 = 2'd0;
        if0.start = 1'b0; if0.expected = '0;
        if1.start = 1'b0; if1.expected = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset1_busy", {31'd0, if1.busy}, 32'd0);
        check("reset1_table", {16'd0, if1.table_out}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Parity, matching mask (table 6996, pass 1).
        go(0, 2'd0, 16'h6996, 1'b0);
        drain(0, 200);

        // Parity, one-bit-off mask (pass 0, first mismatch at code 0).
        go(0, 2'd0, 16'h6997, 1'b0);
        drain(0, 200);

        // !a.b + c.d with SETTLE_CYC=1; mask 88F8 is this function's table.
        go(1, 2'd1, 16'h88F8, 1'b0);
        drain(1, 200);

        // Second start at cycle 10 with a zero mask must be ignored.
        go(0, 2'd0, 16'h6996, 1'b0);
        wait_cyc(last_c0 + 10);
        if0.start = 1'b1; if0.expected = 16'h0000;
        @(negedge clk);
        if0.start = 1'b0;
        drain(0, 200);

        // Reset at cycle 20 aborts; no done afterwards; fresh sweep is complete.
        go(0, 2'd0, 16'h6996, 1'b0);
        wait_cyc(last_c0 + 20);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_busy", {31'd0, if0.busy}, 32'd0);
        go(0, 2'd0, 16'h6996, 1'b0);
        drain(0, 200);

        // Constant-0 function, start held high: re-arm after one idle cycle.
        go(0, 2'd2, 16'h0000, 1'b1);
        push(0, 2'd2, 16'h0000, last_c0 + 50, 2);
        wait_cyc(last_c0 + 50);
        check("gap_busy", {31'd0, if0.busy}, 32'd0);
        check("gap_done", {31'd0, if0.done}, 32'd0);
        wait_cyc(last_c0 + 51);
        if0.start = 1'b0;
        drain(0, 300);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
